soc_bus_decoder: RTL and testbench

//  Upstream neighbour of rom_memory/ram_memory: takes the CPU native memory bus (valid/ready,

---
 rtl/soc_map_pkg.sv | 35 +++
 rtl/soc_bus_decoder_if.sv | 21 ++
 rtl/soc_addr_decode.sv | 45 ++++
 rtl/soc_bus_decoder.sv | 121 ++++++++++++
 tb/tb_soc_bus_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_map_pkg.sv
// Shared SoC address map, response constants and the enums used by the bus decoder.
// Also holds the byte-strobe merge helper used by the MMIO registers.
package soc_map_pkg;

    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE   = 32'h0001_0000;
    localparam logic [31:0] GPIO_ADDR  = 32'h1000_0000;
    localparam logic [31:0] CYCLE_ADDR = 32'h1000_0004;
    localparam logic [31:0] ERR_WORD   = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        SEL_ROM,
        SEL_RAM,
        SEL_GPIO,
        SEL_CYCLE,
        SEL_ERR
    } sel_e;

    typedef enum logic {
        IDLE,
        ACK
    } state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_bus_decoder_if.sv
// CPU native memory bus: valid/ready handshake with address, write data/strobes and read data.
interface soc_bus_decoder_if;

    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_ready, cpu_rdata
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_ready, cpu_rdata
    );

endinterface

// File: rtl/soc_addr_decode.sv
// Pure combinational region decode of a CPU byte address and write strobes.
// ROM writes and any address outside the map select the error response.
module soc_addr_decode #(
    parameter int unsigned ROM_WORDS = 256,
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] RAM_BASE  = soc_map_pkg::RAM_BASE
) (
    input  logic [31:0]       addr_i,
    input  logic [3:0]        wstrb_i,
    output soc_map_pkg::sel_e sel_o,
    output logic              err_o
);

    localparam logic [29:0] RomBaseW  = soc_map_pkg::ROM_BASE[31:2];
    localparam logic [29:0] RamBaseW  = RAM_BASE[31:2];
    localparam logic [29:0] RomWordsW = 30'(ROM_WORDS);
    localparam logic [29:0] RamWordsW = 30'(RAM_WORDS);

    logic [29:0] word_addr;
    logic [29:0] rom_off;
    logic [29:0] ram_off;
    logic        unused_lsb;

    assign unused_lsb = ^addr_i[1:0];

    // Offsets wrap for addresses below a base, so a single unsigned compare covers both bounds.
    always_comb begin
        word_addr = addr_i[31:2];
        rom_off   = word_addr - RomBaseW;
        ram_off   = word_addr - RamBaseW;
        sel_o     = soc_map_pkg::SEL_ERR;
        if (rom_off < RomWordsW) begin
            sel_o = (wstrb_i == 4'b0000) ? soc_map_pkg::SEL_ROM : soc_map_pkg::SEL_ERR;
        end else if (ram_off < RamWordsW) begin
            sel_o = soc_map_pkg::SEL_RAM;
        end else if (word_addr == soc_map_pkg::GPIO_ADDR[31:2]) begin
            sel_o = soc_map_pkg::SEL_GPIO;
        end else if (word_addr == soc_map_pkg::CYCLE_ADDR[31:2]) begin
            sel_o = soc_map_pkg::SEL_CYCLE;
        end
    end

    assign err_o = (sel_o == soc_map_pkg::SEL_ERR);

endmodule

// File: rtl/soc_bus_decoder.sv
// Steers CPU bus transactions to ROM, RAM or local MMIO (GPIO output, cycle counter).
// Every accepted request gets a single-cycle ready strobe in the following cycle.
module soc_bus_decoder #(
    parameter int unsigned ROM_WORDS = 256,
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] RAM_BASE  = soc_map_pkg::RAM_BASE,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    soc_bus_decoder_if.slave    cpu,
    output logic [31:0]         rom_addr,
    input  logic [31:0]         rom_data,
    output logic [3:0]          ram_wen,
    output logic [31:0]         ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata,
    output logic [GPIO_W-1:0]   gpio_out,
    output logic                bus_err
);

    soc_map_pkg::state_e state_q, state_d;
    soc_map_pkg::sel_e   sel_q, sel_d;
    soc_map_pkg::sel_e   dec_sel;
    logic                dec_err;
    logic [31:0]         rdata_q, rdata_d;
    logic [GPIO_W-1:0]   gpio_q, gpio_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [31:0]         gpio_ext;
    logic [31:0]         gpio_merge;

    soc_addr_decode #(
        .ROM_WORDS (ROM_WORDS),
        .RAM_WORDS (RAM_WORDS),
        .RAM_BASE  (RAM_BASE)
    ) u_decode (
        .addr_i  (cpu.cpu_addr),
        .wstrb_i (cpu.cpu_wstrb),
        .sel_o   (dec_sel),
        .err_o   (dec_err)
    );

    assign rom_addr  = cpu.cpu_addr;
    assign ram_addr  = cpu.cpu_addr - RAM_BASE;
    assign ram_wdata = cpu.cpu_wdata;
    assign gpio_out  = gpio_q;
    assign bus_err   = err_q;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rdata_d       = rdata_q;
        gpio_d        = gpio_q;
        cnt_d         = cnt_q + 32'd1;
        err_d         = err_q;
        ram_wen       = 4'b0000;
        cpu.cpu_ready = 1'b0;
        cpu.cpu_rdata = 32'h0;
        gpio_ext      = 32'h0;
        gpio_ext[GPIO_W-1:0] = gpio_q;
        gpio_merge    = gpio_ext;

        unique case (state_q)
            soc_map_pkg::IDLE: begin
                if (cpu.cpu_valid) begin
                    state_d = soc_map_pkg::ACK;
                    sel_d   = dec_sel;
                    err_d   = err_q | dec_err;
                    unique case (dec_sel)
                        soc_map_pkg::SEL_ROM: rdata_d = rom_data;
                        soc_map_pkg::SEL_RAM: begin
                            rdata_d = 32'h0;
                            if (!rst) ram_wen = cpu.cpu_wstrb;
                        end
                        soc_map_pkg::SEL_GPIO: begin
                            rdata_d    = gpio_ext;
                            gpio_merge = soc_map_pkg::apply_wstrb(gpio_ext, cpu.cpu_wdata,
                                                                  cpu.cpu_wstrb);
                            gpio_d     = gpio_merge[GPIO_W-1:0];
                        end
                        soc_map_pkg::SEL_CYCLE: begin
                            rdata_d = cnt_q;
                            // A write replaces this cycle's increment.
                            if (cpu.cpu_wstrb != 4'b0000) begin
                                cnt_d = soc_map_pkg::apply_wstrb(cnt_q, cpu.cpu_wdata,
                                                                 cpu.cpu_wstrb);
                            end
                        end
                        default: rdata_d = soc_map_pkg::ERR_WORD;
                    endcase
                end
            end
            soc_map_pkg::ACK: begin
                state_d       = soc_map_pkg::IDLE;
                cpu.cpu_ready = 1'b1;
                cpu.cpu_rdata = (sel_q == soc_map_pkg::SEL_RAM) ? ram_rdata : rdata_q;
            end
            default: state_d = soc_map_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= soc_map_pkg::IDLE;
            sel_q   <= soc_map_pkg::SEL_ROM;
            rdata_q <= 32'h0;
            gpio_q  <= '0;
            cnt_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            gpio_q  <= gpio_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_soc_bus_decoder.sv
// Randomized bench for soc_bus_decoder with a behavioural bus/memory-map model,
// memory stubs for ROM/RAM and directed literal checks of the key scenarios.
module tb_soc_bus_decoder;

    localparam int unsigned ROM_WORDS = 256;
    localparam int unsigned RAM_WORDS = 256;
    localparam int unsigned GPIO_W    = 8;
    localparam logic [31:0] RAM_BASE  = 32'h0001_0000;
    localparam logic [31:0] GPIO_A    = 32'h1000_0000;
    localparam logic [31:0] CYCLE_A   = 32'h1000_0004;
    localparam logic [31:0] ERR_W     = 32'hDEAD_BEEF;
    localparam logic [31:0] GMASK     = 32'h0000_00FF;

    typedef enum int {R_ROM, R_RAM, R_GPIO, R_CYC, R_UNM} region_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       rom_addr, rom_data;
    logic [3:0]        ram_wen;
    logic [31:0]       ram_addr, ram_wdata, ram_rdata;
    logic [GPIO_W-1:0] gpio_out;
    logic              bus_err;

    soc_bus_decoder_if bus ();

    soc_bus_decoder #(
        .ROM_WORDS (ROM_WORDS),
        .RAM_WORDS (RAM_WORDS),
        .RAM_BASE  (RAM_BASE),
        .GPIO_W    (GPIO_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (bus),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .gpio_out  (gpio_out),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Memory stubs: combinational ROM, registered-read RAM with byte enables.
    logic [31:0] rom_mem [ROM_WORDS];
    logic [31:0] ram_mem [RAM_WORDS];
    logic [31:0] ram_ref [RAM_WORDS];

    assign rom_data = rom_mem[rom_addr[9:2]];

    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr[9:2]];
        for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic region_t region(input logic [31:0] a);
        longint unsigned w;
        w = longint'({a[31:2], 2'b00});
        if (w < longint'(ROM_WORDS) * 4) return R_ROM;
        if (w >= longint'(RAM_BASE) && w < longint'(RAM_BASE) + longint'(RAM_WORDS) * 4)
            return R_RAM;
        if (w == longint'(GPIO_A)) return R_GPIO;
        if (w == longint'(CYCLE_A)) return R_CYC;
        return R_UNM;
    endfunction

    // Reference model: m_ack = a response is due this cycle; m_resp its data when m_chk.
    bit          m_init = 1'b0;
    bit          m_ack  = 1'b0;
    bit          m_chk  = 1'b0;
    bit          m_err  = 1'b0;
    logic [31:0] m_resp = 32'h0;
    logic [31:0] m_gpio = 32'h0;
    logic [31:0] m_cnt  = 32'h0;

    initial begin
        logic [3:0]  exp_wen;
        logic [31:0] ncnt;
        region_t     rg;
        int          idx;
        forever begin
            @(negedge clk);
            rg = region(bus.cpu_addr);
            if (m_init) begin
                check("ready", 32'(bus.cpu_ready), 32'(m_ack));
                if (!m_ack) check("rdata_when_idle", bus.cpu_rdata, 32'h0);
                else if (m_chk) check("rdata", bus.cpu_rdata, m_resp);
                check("gpio_out", 32'(gpio_out), m_gpio);
                check("bus_err", 32'(bus_err), 32'(m_err));
                exp_wen = (!m_ack && bus.cpu_valid && !rst && rg == R_RAM) ? bus.cpu_wstrb : 4'b0;
                check("ram_wen", 32'(ram_wen), 32'(exp_wen));
                if (bus.cpu_valid) begin
                    check("ram_addr", ram_addr, bus.cpu_addr - RAM_BASE);
                    check("ram_wdata", ram_wdata, bus.cpu_wdata);
                end
            end
            if (rst) begin
                m_init = 1'b1;
                m_ack  = 1'b0;
                m_chk  = 1'b0;
                m_err  = 1'b0;
                m_gpio = 32'h0;
                m_cnt  = 32'h0;
            end else if (m_init) begin
                ncnt = m_cnt + 32'd1;
                if (!m_ack && bus.cpu_valid) begin
                    m_ack = 1'b1;
                    m_chk = (bus.cpu_wstrb == 4'b0);
                    case (rg)
                        R_ROM: begin
                            if (bus.cpu_wstrb != 4'b0) begin
                                m_err  = 1'b1;
                                m_chk  = 1'b1;
                                m_resp = ERR_W;
                            end else begin
                                m_resp = rom_mem[bus.cpu_addr[9:2]];
                            end
                        end
                        R_RAM: begin
                            idx = int'((bus.cpu_addr - RAM_BASE) >> 2);
                            m_resp = ram_ref[idx];
                            ram_ref[idx] = merge(ram_ref[idx], bus.cpu_wdata, bus.cpu_wstrb);
                        end
                        R_GPIO: begin
                            m_resp = m_gpio;
                            m_gpio = merge(m_gpio, bus.cpu_wdata, bus.cpu_wstrb) & GMASK;
                        end
                        R_CYC: begin
                            m_resp = m_cnt;
                            if (bus.cpu_wstrb != 4'b0)
                                ncnt = merge(m_cnt, bus.cpu_wdata, bus.cpu_wstrb);
                        end
                        default: begin
                            m_err  = 1'b1;
                            m_chk  = 1'b1;
                            m_resp = ERR_W;
                        end
                    endcase
                end else begin
                    m_ack = 1'b0;
                end
                m_cnt = ncnt;
            end
        end
    end

    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input bit keep, input bit now, output logic [31:0] rd);
        int n;
        bit got;
        if (!now) begin
            @(posedge clk);
            #2;
        end
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_wstrb = ws;
        got = 1'b0;
        n   = 0;
        rd  = 32'h0;
        while (!got && n < 4) begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                got = 1'b1;
                rd  = bus.cpu_rdata;
            end else begin
                n++;
            end
        end
        check("latency", 32'(n), 32'd1);
        if (!keep) begin
            @(posedge clk);
            #2;
            bus.cpu_valid = 1'b0;
            bus.cpu_wstrb = 4'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, r1, r2, a, wd;
        logic [3:0]  ws;
        bit          keep;
        int          kind;

        for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
        for (int i = 0; i < RAM_WORDS; i++) begin
            ram_mem[i] = $urandom;
            ram_ref[i] = ram_mem[i];
        end
        rom_mem[2] = 32'h1234_5678;
        ram_mem[1] = 32'h1122_3344;
        ram_ref[1] = 32'h1122_3344;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.cpu_wstrb = 4'b0;

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // ROM read
        txn(32'h0000_0008, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("t1_rom_rdata", rd, 32'h1234_5678);
        check("t1_bus_err", 32'(bus_err), 32'h0);

        // RAM partial write then read-back
        txn(32'h0001_0004, 32'hAABB_CCDD, 4'b0011, 1'b0, 1'b0, rd);
        txn(32'h0001_0004, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("t2_ram_rdata", rd, 32'h1122_CCDD);

        // GPIO write, read-back, write to a lane above GPIO_W
        txn(GPIO_A, 32'h0000_00A5, 4'b0001, 1'b0, 1'b0, rd);
        check("t3_gpio_after_wr", 32'(gpio_out), 32'h0000_00A5);
        txn(GPIO_A, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("t3_gpio_rdata", rd, 32'h0000_00A5);
        txn(GPIO_A, 32'h0000_FF00, 4'b0010, 1'b0, 1'b0, rd);
        check("t3_gpio_hi_lane", 32'(gpio_out), 32'h0000_00A5);

        // Cycle counter load then back-to-back reads through the wrap
        txn(CYCLE_A, 32'hFFFF_FFFE, 4'b1111, 1'b1, 1'b0, rd);
        txn(CYCLE_A, 32'h0, 4'b0000, 1'b1, 1'b0, r1);
        txn(CYCLE_A, 32'h0, 4'b0000, 1'b0, 1'b0, r2);
        check("t4_cycle_first", r1, 32'hFFFF_FFFF);
        check("t4_cycle_second", r2, 32'h0000_0001);
        check("t4_cycle_delta", r2 - r1, 32'd2);

        // Unmapped read and ROM write both complete with the error word
        txn(32'h2000_0000, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("t5_unmapped_rdata", rd, ERR_W);
        check("t5_bus_err_set", 32'(bus_err), 32'h1);
        txn(32'h0000_0000, 32'h5555_5555, 4'b1111, 1'b0, 1'b0, rd);
        check("t5_romwr_rdata", rd, ERR_W);
        txn(32'h0000_0008, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("t5_rom_after_err", rd, 32'h1234_5678);
        check("t5_bus_err_sticky", 32'(bus_err), 32'h1);

        // Reset asserted during ACK
        @(posedge clk);
        #2;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = GPIO_A;
        bus.cpu_wstrb = 4'b0000;
        @(posedge clk);
        #2;
        check("t6_in_ack", 32'(bus.cpu_ready), 32'h1);
        rst = 1'b1;
        bus.cpu_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("t6_ready_dropped", 32'(bus.cpu_ready), 32'h0);
        check("t6_gpio_cleared", 32'(gpio_out), 32'h0);
        check("t6_err_cleared", 32'(bus_err), 32'h0);
        txn(CYCLE_A, 32'h0, 4'b0000, 1'b0, 1'b1, rd);
        check("t6_counter_cleared", rd, 32'h0);
        txn(32'h0000_0008, 32'h0, 4'b0000, 1'b0, 1'b0, rd);
        check("t6_rom_after_rst", rd, 32'h1234_5678);

        // Random mix across all regions
        for (int t = 0; t < 400; t++) begin
            kind = int'($urandom_range(0, 4));
            ws   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            wd   = $urandom;
            keep = ($urandom_range(0, 1) == 1);
            case (kind)
                0: begin
                    a = 32'($urandom_range(0, ROM_WORDS - 1)) * 4;
                    if ($urandom_range(0, 3) != 0) ws = 4'b0000;
                end
                1: a = RAM_BASE + 32'($urandom_range(0, RAM_WORDS - 1)) * 4;
                2: a = GPIO_A;
                3: begin
                    a = CYCLE_A;
                    if ($urandom_range(0, 3) != 0) ws = 4'b0000;
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'(ROM_WORDS * 4) + 32'($urandom_range(0, 64)) * 4;
                        1: a = RAM_BASE + 32'(RAM_WORDS * 4) + 32'($urandom_range(0, 64)) * 4;
                        2: a = 32'h1000_0008;
                        default: a = 32'h8000_0000 | $urandom;
                    endcase
                end
            endcase
            a = a | 32'($urandom_range(0, 3));
            txn(a, wd, ws, keep, 1'b0, rd);
            if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        @(posedge clk);
        #2;
        bus.cpu_valid = 1'b0;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
